// File: rtl/stopwatch_pkg.sv
// Shared types, constants and helpers for the centisecond stopwatch core.
package stopwatch_pkg;

    localparam int unsigned T_W   = 14;
    localparam int unsigned T_MAX = 9999;

    localparam logic [1:0] MODE_UP_ZERO   = 2'b00;
    localparam logic [1:0] MODE_UP_PRESET = 2'b01;
    localparam logic [1:0] MODE_DN_MAX    = 2'b10;
    localparam logic [1:0] MODE_DN_PRESET = 2'b11;

    typedef enum logic [2:0] {
        LOAD,
        IDLE,
        RUN,
        PAUSE,
        DONE
    } state_t;

    typedef struct packed {
        logic [3:0] thousands;
        logic [3:0] hundreds;
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_t;

    // Seconds preset in centiseconds; out-of-range digits saturate at 9.
    function automatic logic [T_W-1:0] preset_value(input logic [3:0] d1, input logic [3:0] d0);
        logic [T_W-1:0] tens_s;
        logic [T_W-1:0] ones_s;
        tens_s = (d1 > 4'd9) ? T_W'(9) : T_W'(d1);
        ones_s = (d0 > 4'd9) ? T_W'(9) : T_W'(d0);
        return (tens_s * T_W'(1000)) + (ones_s * T_W'(100));
    endfunction

    function automatic bcd_t to_bcd(input logic [T_W-1:0] v);
        bcd_t b;
        b.thousands = 4'(v / T_W'(1000));
        b.hundreds  = 4'((v / T_W'(100)) % T_W'(10));
        b.tens      = 4'((v / T_W'(10)) % T_W'(10));
        b.ones      = 4'(v % T_W'(10));
        return b;
    endfunction

endpackage

// File: rtl/stopwatch_if.sv
// Control and display bundle between the stopwatch core and its user.
interface stopwatch_if;
    import stopwatch_pkg::*;

    logic            start;
    logic [1:0]      mode;
    logic [3:0]      init_0;
    logic [3:0]      init_1;
    logic [T_W-1:0]  t_value;
    logic [15:0]     bcd;
    logic            running;
    logic            done;
    logic            disp_tick;

    modport master (
        output start, mode, init_0, init_1,
        input  t_value, bcd, running, done, disp_tick
    );

    modport slave (
        input  start, mode, init_0, init_1,
        output t_value, bcd, running, done, disp_tick
    );

endinterface

// File: rtl/sw_tick_gen.sv
// Count-tick prescaler (enable + synchronous clear) and free-running display strobe.
module sw_tick_gen #(
    parameter int unsigned TICK_DIV = 1_000_000,
    parameter int unsigned DISP_DIV = 100_000
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_en,
    input  logic tick_clr,
    output logic tick_c,
    output logic disp_tick
);

    localparam int unsigned TC_W = $clog2(TICK_DIV);
    localparam int unsigned DC_W = $clog2(DISP_DIV);

    logic [TC_W-1:0] tick_cnt;
    logic [DC_W-1:0] disp_cnt;

    assign tick_c = (tick_cnt == TC_W'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick_clr) begin
            tick_cnt <= '0;
        end else if (tick_en) begin
            tick_cnt <= tick_c ? '0 : tick_cnt + TC_W'(1);
        end
    end

    // Strobe is registered one count early so it is high exactly while disp_cnt == DISP_DIV-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_cnt  <= '0;
            disp_tick <= 1'b0;
        end else begin
            disp_cnt  <= (disp_cnt == DC_W'(DISP_DIV - 1)) ? '0 : disp_cnt + DC_W'(1);
            disp_tick <= (disp_cnt == DC_W'(DISP_DIV - 2));
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// Centisecond stopwatch: control FSM, 0..9999 count register and BCD view.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1_000_000,
    parameter int unsigned DISP_DIV = 100_000
) (
    input  logic        clk,
    input  logic        rst,
    stopwatch_if.slave  sw
);

    state_t          state;
    state_t          state_nx;
    logic            start_q;
    logic            start_edge_c;
    logic [T_W-1:0]  t_value;
    logic            dir;
    logic            running;
    logic            done;
    logic [T_W-1:0]  load_val_c;
    logic [T_W-1:0]  term_c;
    logic            at_term_c;
    logic            load_en_c;
    logic            step_en_c;
    logic            tick_en_c;
    logic            tick_clr_c;
    logic            tick_c;
    logic            disp_tick;

    assign start_edge_c = sw.start & ~start_q;
    assign term_c       = dir ? '0 : T_W'(T_MAX);
    assign at_term_c    = (t_value == term_c);

    always_comb begin
        load_val_c = '0;
        unique case (sw.mode)
            MODE_UP_ZERO:                   load_val_c = '0;
            MODE_DN_MAX:                    load_val_c = T_W'(T_MAX);
            MODE_UP_PRESET, MODE_DN_PRESET: load_val_c = preset_value(sw.init_1, sw.init_0);
            default:                        load_val_c = '0;
        endcase
    end

    // State register; running/done are registered from the next state to stay aligned with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= LOAD;
            start_q <= 1'b0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            start_q <= sw.start;
            running <= (state_nx == RUN);
            done    <= (state_nx == DONE);
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            LOAD:  state_nx = IDLE;
            IDLE:  if (start_edge_c) state_nx = RUN;
            RUN: begin
                if (at_term_c)         state_nx = DONE;
                else if (start_edge_c) state_nx = PAUSE;
            end
            PAUSE: if (start_edge_c) state_nx = RUN;
            DONE:  state_nx = DONE;
            default: state_nx = LOAD;
        endcase
    end

    // A start edge in RUN wins over a coincident tick, so pausing never steps.
    always_comb begin
        load_en_c  = 1'b0;
        step_en_c  = 1'b0;
        tick_en_c  = 1'b0;
        tick_clr_c = 1'b0;
        unique case (state)
            LOAD:  load_en_c = 1'b1;
            IDLE: begin
                load_en_c  = 1'b1;
                tick_clr_c = start_edge_c;
            end
            RUN: begin
                tick_en_c = 1'b1;
                step_en_c = tick_c & ~at_term_c & ~start_edge_c;
            end
            PAUSE: tick_clr_c = start_edge_c;
            DONE:  ;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_value <= '0;
            dir     <= 1'b0;
        end else if (load_en_c) begin
            t_value <= load_val_c;
            dir     <= sw.mode[1];
        end else if (step_en_c) begin
            t_value <= dir ? t_value - T_W'(1) : t_value + T_W'(1);
        end
    end

    sw_tick_gen #(
        .TICK_DIV (TICK_DIV),
        .DISP_DIV (DISP_DIV)
    ) u_tick_gen (
        .clk       (clk),
        .rst       (rst),
        .tick_en   (tick_en_c),
        .tick_clr  (tick_clr_c),
        .tick_c    (tick_c),
        .disp_tick (disp_tick)
    );

    assign sw.t_value   = t_value;
    assign sw.bcd       = to_bcd(t_value);
    assign sw.running   = running;
    assign sw.done      = done;
    assign sw.disp_tick = disp_tick;

endmodule

// File: tb/tb_stopwatch_core.sv
// Scoreboard bench for stopwatch_core with short prescalers (TICK_DIV=4, DISP_DIV=3).
module tb_stopwatch_core;

    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned DISP_DIV = 3;

    typedef struct {
        string       tag;
        logic [13:0] t;
        logic [15:0] bcd;
        logic        run;
        logic        dn;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb[$];
    int   vectors;
    int   errors;

    stopwatch_if sw ();

    stopwatch_core #(
        .TICK_DIV (TICK_DIV),
        .DISP_DIV (DISP_DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sw  (sw)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, vectors=%0d", vectors);
        $fatal(1, "stopwatch bench timeout");
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        sw.start = 1'b1;
        @(negedge clk);
        sw.start = 1'b0;
    endtask

    task automatic push(input string tag, input logic [13:0] t, input logic [15:0] b,
                        input logic r, input logic d);
        exp_t e;
        e.tag = tag; e.t = t; e.bcd = b; e.run = r; e.dn = d;
        sb.push_back(e);
    endtask

    task automatic apply_reset(input logic [1:0] m, input logic [3:0] i1, input logic [3:0] i0);
        sw.mode = m; sw.init_1 = i1; sw.init_0 = i0; sw.start = 1'b0;
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        exp_t       e;
        logic [8:0] hits;
        @(negedge clk);
        push("in_reset", 14'd0, 16'h0000, 1'b0, 1'b0);
        e = sb.pop_front(); vectors++;
        if ({sw.t_value, sw.bcd, sw.running, sw.done} !== {e.t, e.bcd, e.run, e.dn}) begin
            errors++;
            $display("FAIL %s: got t=%0d bcd=%h run=%b done=%b, want t=%0d bcd=%h run=%b done=%b",
                     e.tag, sw.t_value, sw.bcd, sw.running, sw.done, e.t, e.bcd, e.run, e.dn);
        end
        vectors++;
        if (sw.disp_tick !== 1'b0) begin
            errors++;
            $display("FAIL disp_in_reset: got %b, want 0", sw.disp_tick);
        end
        rst = 1'b0;
        push("after_reset", 14'd0, 16'h0000, 1'b0, 1'b0);
        cycles(5);
        e = sb.pop_front(); vectors++;
        if ({sw.t_value, sw.bcd, sw.running, sw.done} !== {e.t, e.bcd, e.run, e.dn}) begin
            errors++;
            $display("FAIL %s: got t=%0d bcd=%h run=%b done=%b, want t=%0d bcd=%h run=%b done=%b",
                     e.tag, sw.t_value, sw.bcd, sw.running, sw.done, e.t, e.bcd, e.run, e.dn);
        end
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            hits[i] = sw.disp_tick;
        end
        vectors++;
        if (!(hits == 9'b001001001 || hits == 9'b010010010 || hits == 9'b100100100)) begin
            errors++;
            $display("FAIL disp_period: got pattern %b, want one pulse every 3 cycles", hits);
        end
    endtask

    task automatic test_preset_run();
        exp_t e;
        sw.mode = 2'b01; sw.init_1 = 4'd4; sw.init_0 = 4'd2;
        push("preset_idle", 14'd4200, 16'h4200, 1'b0, 1'b0);
        cycles(2);
        e = sb.pop_front(); vectors++;
        if ({sw.t_value, sw.bcd, sw.running, sw.done} !== {e.t, e.bcd, e.run, e.dn}) begin
            errors++;
            $display("FAIL %s: got t=%0d bcd=%h run=%b done=%b, want t=%0d bcd=%h run=%b done=%b",
                     e.tag, sw.t_value, sw.bcd, sw.running, sw.done, e.t, e.bcd, e.run, e.dn);
        end
        push("before_first_tick", 14'd4200, 16'h4200, 1'b1, 1'b0);
        push("first_tick", 14'd4201, 16'h4201, 1'b1, 1'b0);
        push("preset_40cyc", 14'd4210, 16'h4210, 1'b1, 1'b0);
        pulse_start();
        cycles(3);
        for (int k = 0; k < 3; k++) begin
            e = sb.pop_front(); vectors++;
            if ({sw.t_value, sw.bcd, sw.running, sw.done} !== {e.t, e.bcd, e.run, e.dn}) begin
                errors++;
                $display("FAIL %s: got t=%0d bcd=%h run=%b done=%b, want t=%0d bcd=%h run=%b done=%b",
                         e.tag, sw.t_value, sw.bcd, sw.running, sw.done, e.t, e.bcd, e.run, e.dn);
            end
            cycles(k == 0 ? 1 : 36);
        end
    endtask

    task automatic test_down_pause();
        exp_t e;
        apply_reset(2'b10, 4'd0, 4'd0);
        push("down_idle", 14'd9999, 16'h9999, 1'b0, 1'b0);
        push("down_running", 14'd9997, 16'h9997, 1'b1, 1'b0);
        push("pause_no_step", 14'd9997, 16'h9997, 1'b0, 1'b0);
        push("pause_hold", 14'd9997, 16'h9997, 1'b0, 1'b0);
        push("resume_full_period", 14'd9997, 16'h9997, 1'b1, 1'b0);
        push("resume_step_down", 14'd9996, 16'h9996, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            case (k)
                0: cycles(2);
                1: begin pulse_start(); cycles(11); end
                2: pulse_start();
                3: begin sw.mode = 2'b00; sw.init_1 = 4'd5; cycles(20); end
                4: begin pulse_start(); cycles(3); end
                default: cycles(1);
            endcase
            e = sb.pop_front(); vectors++;
            if ({sw.t_value, sw.bcd, sw.running, sw.done} !== {e.t, e.bcd, e.run, e.dn}) begin
                errors++;
                $display("FAIL %s: got t=%0d bcd=%h run=%b done=%b, want t=%0d bcd=%h run=%b done=%b",
                         e.tag, sw.t_value, sw.bcd, sw.running, sw.done, e.t, e.bcd, e.run, e.dn);
            end
        end
    endtask

    task automatic test_terminal_up();
        exp_t e;
        int   ticks;
        apply_reset(2'b01, 4'd9, 4'd9);
        push("near_max_idle", 14'd9900, 16'h9900, 1'b0, 1'b0);
        cycles(2);
        e = sb.pop_front(); vectors++;
        if ({sw.t_value, sw.bcd, sw.running, sw.done} !== {e.t, e.bcd, e.run, e.dn}) begin
            errors++;
            $display("FAIL %s: got t=%0d bcd=%h run=%b done=%b, want t=%0d bcd=%h run=%b done=%b",
                     e.tag, sw.t_value, sw.bcd, sw.running, sw.done, e.t, e.bcd, e.run, e.dn);
        end
        pulse_start();
        cycles(36);
        ticks = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (sw.disp_tick === 1'b1) ticks++;
        end
        vectors++;
        if (ticks != 10) begin
            errors++;
            $display("FAIL disp_in_run: got %0d strobes in 30 cycles, want 10", ticks);
        end
        push("reach_max", 14'd9999, 16'h9999, 1'b1, 1'b0);
        push("done_next", 14'd9999, 16'h9999, 1'b0, 1'b1);
        push("done_sticky", 14'd9999, 16'h9999, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: cycles(330);
                1: cycles(1);
                default: begin
                    pulse_start(); sw.mode = 2'b10; cycles(3); pulse_start(); cycles(10);
                end
            endcase
            e = sb.pop_front(); vectors++;
            if ({sw.t_value, sw.bcd, sw.running, sw.done} !== {e.t, e.bcd, e.run, e.dn}) begin
                errors++;
                $display("FAIL %s: got t=%0d bcd=%h run=%b done=%b, want t=%0d bcd=%h run=%b done=%b",
                         e.tag, sw.t_value, sw.bcd, sw.running, sw.done, e.t, e.bcd, e.run, e.dn);
            end
        end
    endtask

    task automatic test_preset_zero();
        exp_t e;
        apply_reset(2'b11, 4'd0, 4'd0);
        push("zero_idle", 14'd0, 16'h0000, 1'b0, 1'b0);
        push("zero_first_run", 14'd0, 16'h0000, 1'b1, 1'b0);
        push("zero_done", 14'd0, 16'h0000, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: cycles(2);
                1: pulse_start();
                default: cycles(1);
            endcase
            e = sb.pop_front(); vectors++;
            if ({sw.t_value, sw.bcd, sw.running, sw.done} !== {e.t, e.bcd, e.run, e.dn}) begin
                errors++;
                $display("FAIL %s: got t=%0d bcd=%h run=%b done=%b, want t=%0d bcd=%h run=%b done=%b",
                         e.tag, sw.t_value, sw.bcd, sw.running, sw.done, e.t, e.bcd, e.run, e.dn);
            end
        end
    endtask

    task automatic test_invalid_bcd_reset();
        exp_t e;
        apply_reset(2'b01, 4'd12, 4'd0);
        push("clamp_tens", 14'd9000, 16'h9000, 1'b0, 1'b0);
        push("clamp_both_live", 14'd9900, 16'h9900, 1'b0, 1'b0);
        push("live_back", 14'd9000, 16'h9000, 1'b0, 1'b0);
        push("clamp_running", 14'd9002, 16'h9002, 1'b1, 1'b0);
        push("async_reset", 14'd0, 16'h0000, 1'b0, 1'b0);
        push("reload_after_reset", 14'd9000, 16'h9000, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            case (k)
                0: cycles(2);
                1: begin sw.init_0 = 4'd11; cycles(1); end
                2: begin sw.init_0 = 4'd0; cycles(1); end
                3: begin pulse_start(); cycles(8); end
                4: begin #2; rst = 1'b1; #1; end
                default: begin @(negedge clk); rst = 1'b0; cycles(2); end
            endcase
            e = sb.pop_front(); vectors++;
            if ({sw.t_value, sw.bcd, sw.running, sw.done} !== {e.t, e.bcd, e.run, e.dn}) begin
                errors++;
                $display("FAIL %s: got t=%0d bcd=%h run=%b done=%b, want t=%0d bcd=%h run=%b done=%b",
                         e.tag, sw.t_value, sw.bcd, sw.running, sw.done, e.t, e.bcd, e.run, e.dn);
            end
            if (k == 4) begin
                vectors++;
                if (sw.disp_tick !== 1'b0) begin
                    errors++;
                    $display("FAIL disp_async_reset: got %b, want 0", sw.disp_tick);
                end
            end
        end
    endtask

    initial begin
        vectors   = 0;
        errors    = 0;
        rst       = 1'b1;
        sw.start  = 1'b0;
        sw.mode   = 2'b00;
        sw.init_0 = 4'd0;
        sw.init_1 = 4'd0;
        test_reset();
        test_preset_run();
        test_down_pause();
        test_terminal_up();
        test_preset_zero();
        test_invalid_bcd_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
